bin2bcd_seq: RTL

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It sits directly downstream of the calculator's operation selector. It takes the selected result and its sign, and produces registered hundreds/tens/ones digits plus a leading-zero blank mask. The 7-segment digit scanner reads these outputs, so the scanner no longer needs combinational divide/modulo logic.

---
 rtl/bin2bcd_seq_pkg.sv | 24 ++
 rtl/bin2bcd_seq_adjust.sv | 19 +
 rtl/bin2bcd_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  // A nibble at or above this value must be corrected before the next shift
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  // Correction added to a nibble so that doubling it carries into the next digit
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // 10^n as a 64-bit value, used for the overflow compare
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adjust.sv
// One BCD digit correction step: add 3 when the nibble is 5 or more.
module bcd_adjust_nibble
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Correct the nibble so the following left shift produces a valid BCD carry
  always_comb begin
    nib_o = nib_i;
    if (nib_i >= ADJ_THRESH) begin
      nib_o = nib_i + ADJ_ADD;
    end else begin
      nib_o = nib_i;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with leading-zero blank mask.
// Outputs are updated only on the done edge so a display never sees partial digits.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  sign_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic                  ovf
);

  localparam int unsigned BW  = 4 * DIGITS;
  localparam int unsigned SRW = BW + WIDTH;
  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [63:0]   LIMIT    = pow10(DIGITS);

  state_e             state_q, state_d;
  logic [SRW-1:0]     sr_q, sr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sign_lat_q, sign_lat_d;
  logic               ovf_lat_q, ovf_lat_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [BW-1:0]      adj_s;
  logic [SRW-1:0]     sr_shift_s;
  logic [DIGITS-1:0]  blank_s;
  logic               zero_run_s;

  // One correction unit per BCD digit of the shift register
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_adjust_nibble u_adj (
      .nib_i (sr_q[WIDTH + 4*d +: 4]),
      .nib_o (adj_s[4*d +: 4])
    );
  end

  // Corrected digits plus remaining binary bits, shifted left once; the top carry is dropped
  assign sr_shift_s = {adj_s, sr_q[WIDTH-1:0]} << 1;

  // Blank a digit when it and every more significant digit are zero; ones never blanks
  always_comb begin
    blank_s    = '0;
    zero_run_s = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run_s = zero_run_s & (sr_shift_s[WIDTH + 4*i +: 4] == 4'd0);
      blank_s[i] = zero_run_s;
    end
  end

  // FSM next state, shift/count datapath and done-edge output capture
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    sign_lat_d = sign_lat_q;
    ovf_lat_d  = ovf_lat_q;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    blank_d    = blank_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d       = {{BW{1'b0}}, bin_in};
          sign_lat_d = sign_in;
          ovf_lat_d  = (64'(bin_in) >= LIMIT);
          cnt_d      = '0;
          state_d    = CONV;
        end else begin
          state_d    = IDLE;
        end
      end
      CONV: begin
        sr_d  = sr_shift_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          bcd_d   = sr_shift_s[SRW-1 -: BW];
          sign_d  = sign_lat_q;
          ovf_d   = ovf_lat_q;
          blank_d = blank_s;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = CONV;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      sign_lat_q <= 1'b0;
      ovf_lat_q  <= 1'b0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      blank_q    <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      sign_lat_q <= sign_lat_d;
      ovf_lat_q  <= ovf_lat_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      blank_q    <= blank_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q == CONV);
  assign done      = done_q;
  assign bcd_out   = bcd_q;
  assign sign_out  = sign_q;
  assign blank_out = blank_q;
  assign ovf       = ovf_q;

endmodule
